// File: rtl/mbist_pkg.sv
// Shared types, widths and the march element table for the MBIST march sequencer.
package mbist_pkg;

    localparam int CNT_W  = 12;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef enum logic [2:0] {W0, W1, R0, R1, NOP} op_e;

    // Rows are march elements E0..E2, columns are the four op slots per address.
    function automatic op_e march_op(input logic [1:0] elem, input logic [1:0] slot);
        op_e op;
        case ({elem, slot})
            4'b00_00: op = W0;
            4'b00_01: op = R0;
            4'b01_00: op = R0;
            4'b01_01: op = W1;
            4'b01_10: op = R1;
            4'b10_00: op = R1;
            4'b10_01: op = W0;
            4'b10_10: op = R0;
            default:  op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mbist_rd_pipe.sv
// Read-tracking delay line: carries {valid, addr, expected} for RD_LAT clocks so the
// compare lines up with the cycle the RAM returns data.
module mbist_rd_pipe
    import mbist_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] exp_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] exp_o
);

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic              vld_q;
        logic [ADDR_W-1:0] addr_q;
        logic [DATA_W-1:0] exp_q;
        logic              vld_in;
        logic [ADDR_W-1:0] addr_in;
        logic [DATA_W-1:0] exp_in;

        if (gi == 0) begin : g_head
            assign vld_in  = vld_i;
            assign addr_in = addr_i;
            assign exp_in  = exp_i;
        end else begin : g_tail
            assign vld_in  = g_stage[gi-1].vld_q;
            assign addr_in = g_stage[gi-1].addr_q;
            assign exp_in  = g_stage[gi-1].exp_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                addr_q <= '0;
                exp_q  <= '0;
            end else begin
                vld_q  <= vld_in;
                addr_q <= addr_in;
                exp_q  <= exp_in;
            end
        end
    end

    assign vld_o  = g_stage[RD_LAT-1].vld_q;
    assign addr_o = g_stage[RD_LAT-1].addr_q;
    assign exp_o  = g_stage[RD_LAT-1].exp_q;

endmodule

// File: rtl/mbist_march_seq.sv
// March sequencer: steps the external address/phase counter, turns each count into a
// RAM command and checks returned read data, reporting first-fail details and error count.
module mbist_march_seq
    import mbist_pkg::*;
#(
    parameter logic [DATA_W-1:0] BG_PAT = 4'b0101,
    parameter int                RD_LAT = 1,
    parameter int                ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cnt_q,
    input  logic              cnt_stop,
    output logic              cnt_en,
    output logic              cnt_ud,
    output logic              cnt_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ERR_W-1:0]  err_count
);

    state_e            state_q, state_d;
    logic [2:0]        drain_q, drain_d;
    logic              issue, status_clr;
    op_e               op;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, re_q, re_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, exp_q, exp_d;

    logic              pipe_vld;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_exp;

    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic [ERR_W-1:0]  err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        cnt_en     = 1'b0;
        cnt_rst    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        status_clr = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_rst = 1'b1;
                if (start) begin
                    state_d    = RUN;
                    status_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                busy   = 1'b1;
                if (cnt_stop) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                // 1+RD_LAT cycles here lets the last read reach the comparator.
                busy = 1'b1;
                if (drain_q == 3'(RD_LAT)) state_d = DONE;
                else                       drain_d = drain_q + 3'd1;
            end
            DONE: begin
                done    = 1'b1;
                cnt_rst = 1'b1;
                if (start) begin
                    state_d    = RUN;
                    status_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op      = issue ? march_op(cnt_q[11:10], cnt_q[1:0]) : NOP;
        addr_d  = issue ? cnt_q[9:2] : '0;
        we_d    = (op == W0) || (op == W1);
        re_d    = (op == R0) || (op == R1);
        wdata_d = (op == W1) ? ~BG_PAT : ((op == W0) ? BG_PAT : '0);
        exp_d   = (op == R1) ? ~BG_PAT : ((op == R0) ? BG_PAT : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wdata_q <= '0;
            exp_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wdata_q <= wdata_d;
            exp_q   <= exp_d;
        end
    end

    mbist_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (re_q),
        .addr_i (addr_q),
        .exp_i  (exp_q),
        .vld_o  (pipe_vld),
        .addr_o (pipe_addr),
        .exp_o  (pipe_exp)
    );

    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        err_d       = err_q;
        if (status_clr) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            err_d       = '0;
        end else if (pipe_vld && (mem_rdata != pipe_exp)) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = pipe_addr;
                fail_exp_d  = pipe_exp;
                fail_got_d  = mem_rdata;
            end
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            err_q       <= '0;
        end else begin
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            err_q       <= err_d;
        end
    end

    assign cnt_ud    = 1'b1;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign mem_wdata = wdata_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_mbist_march_seq.sv
// Directed bench: three sequencer instances (RD_LAT=1 / RD_LAT=3 / ERR_W=4), each with
// its own counter and RAM model; RAM faults are selected per instance.
module tb_mbist_march_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start [3];
    int   fault_mode [3];
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;
    int   n;

    logic [2:0]        done_v, busy_v, fail_v, we_v, re_v, cnt_rst_v, cnt_en_v, cnt_ud_v;
    logic [2:0][7:0]   fail_addr_v, err_v;
    logic [2:0][3:0]   fail_exp_v, fail_got_v;
    logic [2:0][11:0]  cnt_v;
    logic [2:0][31:0]  we_n_v, re_n_v;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 1) ? 3 : 1;
        localparam int EW  = (gi == 2) ? 4 : 8;

        logic [11:0]   cnt;
        logic          cnt_stop, cnt_en, cnt_ud, cnt_rst;
        logic [7:0]    mem_addr;
        logic          mem_we, mem_re;
        logic [3:0]    mem_wdata, mem_rdata;
        logic          busy, done, fail;
        logic [7:0]    fail_addr;
        logic [3:0]    fail_exp, fail_got;
        logic [EW-1:0] err_count;
        logic [3:0]    ram [256];
        logic [3:0]    rd_d [LAT];
        logic [LAT-1:0] rd_v;
        logic [3:0]    rd_now;
        int            we_n, re_n;

        mbist_march_seq #(.BG_PAT(4'b0101), .RD_LAT(LAT), .ERR_W(EW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[gi]),
            .cnt_q     (cnt),
            .cnt_stop  (cnt_stop),
            .cnt_en    (cnt_en),
            .cnt_ud    (cnt_ud),
            .cnt_rst   (cnt_rst),
            .mem_addr  (mem_addr),
            .mem_we    (mem_we),
            .mem_re    (mem_re),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy),
            .done      (done),
            .fail      (fail),
            .fail_addr (fail_addr),
            .fail_exp  (fail_exp),
            .fail_got  (fail_got),
            .err_count (err_count)
        );

        assign cnt_stop = (cnt[11:10] == 2'b11);

        always_comb begin
            rd_now = ram[mem_addr];
            if (fault_mode[gi] == 1 && mem_addr == 8'h2A) rd_now = rd_now & 4'b1110;
            else if (fault_mode[gi] == 2)                 rd_now = ~rd_now;
        end

        always @(posedge clk) begin
            if (cnt_rst)     cnt <= 12'h000;
            else if (cnt_en) cnt <= cnt_stop ? 12'h000 : cnt + 12'h001;
            if (mem_we) ram[mem_addr] <= mem_wdata;
            rd_d[0] <= rd_now;
            rd_v[0] <= mem_re;
            for (int i = 1; i < LAT; i++) begin
                rd_d[i] <= rd_d[i-1];
                rd_v[i] <= rd_v[i-1];
            end
            if (start[gi]) begin
                we_n <= 0;
                re_n <= 0;
            end else begin
                if (mem_we) we_n <= we_n + 1;
                if (mem_re) re_n <= re_n + 1;
            end
        end

        // Garbage (0011, unlike either data pattern) whenever no read data is due.
        assign mem_rdata = rd_v[LAT-1] ? rd_d[LAT-1] : 4'b0011;

        assign done_v[gi]      = done;
        assign busy_v[gi]      = busy;
        assign fail_v[gi]      = fail;
        assign we_v[gi]        = mem_we;
        assign re_v[gi]        = mem_re;
        assign cnt_rst_v[gi]   = cnt_rst;
        assign cnt_en_v[gi]    = cnt_en;
        assign cnt_ud_v[gi]    = cnt_ud;
        assign fail_addr_v[gi] = fail_addr;
        assign fail_exp_v[gi]  = fail_exp;
        assign fail_got_v[gi]  = fail_got;
        assign err_v[gi]       = 8'(err_count);
        assign cnt_v[gi]       = cnt;
        assign we_n_v[gi]      = 32'(we_n);
        assign re_n_v[gi]      = 32'(re_n);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a test on instance k, optionally pulse start again pulse_at cycles in,
    // and return the clock count from the start-sampling edge to done.
    task automatic run(input int k, input int pulse_at, output int cycles);
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        cycles = 0;
        check($sformatf("launch_busy%0d", k), 32'(busy_v[k]), 32'd1);
        check($sformatf("launch_done%0d", k), 32'(done_v[k]), 32'd0);
        check($sformatf("launch_fail%0d", k), 32'(fail_v[k]), 32'd0);
        check($sformatf("launch_err%0d", k),  32'(err_v[k]),  32'd0);
        while (!done_v[k] && cycles < 5000) begin
            @(posedge clk);
            #1;
            cycles++;
            start[k] = (cycles == pulse_at);
        end
        start[k] = 1'b0;
        check($sformatf("busy_at_done%0d", k), 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i]      = 1'b0;
            fault_mode[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(busy_v[0]),      32'd0);
        check("rst_done",    32'(done_v[0]),      32'd0);
        check("rst_fail",    32'(fail_v[0]),      32'd0);
        check("rst_cnt_rst", 32'(cnt_rst_v[0]),   32'd1);
        check("rst_cnt_ud",  32'(cnt_ud_v[0]),    32'd1);
        check("rst_cnt_en",  32'(cnt_en_v[0]),    32'd0);
        check("rst_we",      32'(we_v[0]),        32'd0);
        check("rst_re",      32'(re_v[0]),        32'd0);
        check("rst_err",     32'(err_v[0]),       32'd0);
        check("rst_faddr",   32'(fail_addr_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fault-free run, RD_LAT=1
        run(0, -1, n);
        check("t1_cycles", n,                   32'd3075);
        check("t1_done",   32'(done_v[0]),      32'd1);
        check("t1_fail",   32'(fail_v[0]),      32'd0);
        check("t1_err",    32'(err_v[0]),       32'd0);
        check("t1_we_n",   we_n_v[0],           32'd768);
        check("t1_re_n",   re_n_v[0],           32'd1280);
        $display("t1 clean run: cycles=%0d we=%0d re=%0d", n, we_n_v[0], re_n_v[0]);

        // start pulsed mid-run must not disturb the sequence
        run(0, 100, n);
        check("t6_ignore_cycles", n,              32'd3075);
        check("t6_ignore_fail",   32'(fail_v[0]), 32'd0);
        $display("t6 start during RUN: cycles=%0d", n);

        // Address 0x2A bit0 stuck-at-0
        fault_mode[0] = 1;
        run(0, -1, n);
        check("t2_cycles", n,                   32'd3075);
        check("t2_fail",   32'(fail_v[0]),      32'd1);
        check("t2_faddr",  32'(fail_addr_v[0]), 32'h2A);
        check("t2_fexp",   32'(fail_exp_v[0]),  32'h5);
        check("t2_fgot",   32'(fail_got_v[0]),  32'h4);
        check("t2_err",    32'(err_v[0]),       32'd3);
        $display("t2 stuck-at: addr=%0h exp=%0h got=%0h err=%0d",
                 fail_addr_v[0], fail_exp_v[0], fail_got_v[0], err_v[0]);

        // Restart from DONE after a failing run; launch checks confirm status clear
        fault_mode[0] = 0;
        run(0, -1, n);
        check("t6_rerun_cycles", n,              32'd3075);
        check("t6_rerun_fail",   32'(fail_v[0]), 32'd0);
        check("t6_rerun_err",    32'(err_v[0]),  32'd0);
        $display("t6 rerun after fail: fail=%0d err=%0d", fail_v[0], err_v[0]);

        // Reset in the middle of a run
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        n = 0;
        while (cnt_v[0] != 12'h500 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_reach", 32'(cnt_v[0]), 32'h500);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy",    32'(busy_v[0]),    32'd0);
        check("t5_cnt_rst", 32'(cnt_rst_v[0]), 32'd1);
        check("t5_we",      32'(we_v[0]),      32'd0);
        check("t5_re",      32'(re_v[0]),      32'd0);
        check("t5_done",    32'(done_v[0]),    32'd0);
        rst = 1'b0;
        $display("t5 mid-run reset: busy=%0d cnt_rst=%0d", busy_v[0], cnt_rst_v[0]);
        run(0, -1, n);
        check("t5_rerun_cycles", n,              32'd3075);
        check("t5_rerun_fail",   32'(fail_v[0]), 32'd0);

        // RD_LAT=3 with garbage on rdata outside valid slots
        run(1, -1, n);
        check("t3_cycles", n,              32'd3077);
        check("t3_fail",   32'(fail_v[1]), 32'd0);
        check("t3_err",    32'(err_v[1]),  32'd0);
        check("t3_re_n",   re_n_v[1],      32'd1280);
        $display("t3 RD_LAT=3: cycles=%0d fail=%0d", n, fail_v[1]);

        // Every read inverted, 4-bit error counter
        fault_mode[2] = 2;
        run(2, -1, n);
        check("t4_cycles", n,                   32'd3075);
        check("t4_fail",   32'(fail_v[2]),      32'd1);
        check("t4_err",    32'(err_v[2]),       32'd15);
        check("t4_faddr",  32'(fail_addr_v[2]), 32'h00);
        check("t4_fexp",   32'(fail_exp_v[2]),  32'h5);
        check("t4_fgot",   32'(fail_got_v[2]),  32'hA);
        $display("t4 inverted RAM: err=%0d addr=%0h", err_v[2], fail_addr_v[2]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
